// File: rtl/addsub_arbiter_if.sv
// Bus bundle between the addsub_arbiter, its requesting clients and the
// shared combinational addsub unit. The ovf line exists only when
// ADDSUB_ARB_OVF_EN is defined.
interface addsub_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  // Client request side
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] dataa_in;
  logic [NREQ*WIDTH-1:0] datab_in;
  logic [NREQ-1:0]       add_sub_in;
  // Shared addsub unit side
  logic [WIDTH-1:0]      as_dataa;
  logic [WIDTH-1:0]      as_datab;
  logic                  as_add_sub;
  logic [WIDTH-1:0]      as_result;
  // Client response side
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result_out;
`ifdef ADDSUB_ARB_OVF_EN
  logic                  ovf;
`endif

  // Arbiter view
  modport slave (
    input  req, dataa_in, datab_in, add_sub_in, as_result,
    output as_dataa, as_datab, as_add_sub, grant, done, result_out
`ifdef ADDSUB_ARB_OVF_EN
    , output ovf
`endif
  );

  // Environment view (clients plus the addsub unit)
  modport master (
    output req, dataa_in, datab_in, add_sub_in, as_result,
    input  as_dataa, as_datab, as_add_sub, grant, done, result_out
`ifdef ADDSUB_ARB_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational addsub unit among
// NREQ requesters. The winner's operands are registered onto the addsub
// inputs (OP), the result is captured one cycle later and returned with a
// one-cycle done pulse (DONE). Under back-to-back load DONE goes straight to
// OP, giving one operation every two cycles.
// Optional feature: define ADDSUB_ARB_OVF_EN to add the registered signed
// overflow flag (bus.ovf).
module addsub_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic             clk,
  input  logic             reset,
  addsub_arbiter_if.slave  bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [IDXW-1:0]         r_ptr;
  logic [IDXW-1:0]         r_idx;
  logic [IDXW-1:0]         w_idx_inc;
  logic [IDXW-1:0]         w_base;
  logic [IDXW-1:0]         w_win_idx;
  logic                    w_win_vld;
  logic [NREQ-1:0]         w_elig;
  logic [NREQ-1:0]         w_idx_onehot;
  logic [NREQ-1:0]         w_win_onehot;

  logic signed [WIDTH-1:0] r_as_dataa;
  logic signed [WIDTH-1:0] r_as_datab;
  logic                    r_as_add_sub;
  logic signed [WIDTH-1:0] r_result;
  logic [NREQ-1:0]         r_grant;
  logic [NREQ-1:0]         r_done;

  // Next requester index after i, wrapping NREQ-1 back to 0.
  function automatic logic [IDXW-1:0] idx_inc(input logic [IDXW-1:0] i);
    if (int'(i) == NREQ - 1) begin
      return '0;
    end
    return IDXW'(int'(i) + 1);
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

`ifdef ADDSUB_ARB_OVF_EN
  // Signed overflow: effective operands (A, B for add; A, -B for subtract)
  // share a sign and the wrapped result's sign differs from it. The sign of
  // -B is taken as the inverse of B's sign, so 0 - (-2^(W-1)) flags too.
  function automatic logic ovf_calc(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r,
                                    input logic                    add);
    logic sa;
    logic sb_eff;
    sa     = a[WIDTH-1];
    sb_eff = add ? b[WIDTH-1] : ~b[WIDTH-1];
    return (sa == sb_eff) && (r[WIDTH-1] != sa);
  endfunction

  logic r_ovf;
`endif

  assign w_idx_inc    = idx_inc(r_idx);
  assign w_idx_onehot = onehot(r_idx);
  assign w_win_onehot = onehot(w_win_idx);

  // Eligible vector and search start: IDLE searches req from ptr; DONE masks
  // the current winner and searches from the pointer being written this edge.
  always_comb begin
    w_elig = '0;
    w_base = r_ptr;
    case (r_state)
      S_IDLE: begin
        w_elig = bus.req;
      end
      S_DONE: begin
        w_elig = bus.req & ~w_idx_onehot;
        w_base = w_idx_inc;
      end
      default: begin
        w_elig = '0;
      end
    endcase
  end

  // Round-robin pick: walk from w_base downward in priority so the closest
  // set bit at or after the base is the final assignment.
  always_comb begin
    int pos;
    pos       = 0;
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(w_base) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      if (w_elig[pos]) begin
        w_win_vld = 1'b1;
        w_win_idx = IDXW'(pos);
      end
    end
  end

  // FSM next state: OP always completes; IDLE/DONE start a new OP on a win.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = w_win_vld ? S_OP : S_IDLE;
      S_OP:    w_next_state = S_DONE;
      S_DONE:  w_next_state = w_win_vld ? S_OP : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Control: winner index, grant/done strobes and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_idx   <= '0;
      r_grant <= '0;
      r_done  <= '0;
    end else begin
      case (r_state)
        S_OP: begin
          r_grant <= '0;
          r_done  <= w_idx_onehot;
        end
        S_DONE: begin
          r_done  <= '0;
          r_ptr   <= w_idx_inc;
        end
        default: begin
          r_done  <= '0;
        end
      endcase
      if (w_win_vld) begin
        r_idx   <= w_win_idx;
        r_grant <= w_win_onehot;
      end
    end
  end

  // Operand latch: requester inputs are sampled only on the granting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_as_dataa   <= '0;
      r_as_datab   <= '0;
      r_as_add_sub <= 1'b0;
    end else if (w_win_vld) begin
      r_as_dataa   <= bus.dataa_in[int'(w_win_idx)*WIDTH +: WIDTH];
      r_as_datab   <= bus.datab_in[int'(w_win_idx)*WIDTH +: WIDTH];
      r_as_add_sub <= bus.add_sub_in[w_win_idx];
    end
  end

  // Result capture on the OP -> DONE edge; held until the next capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
    end else if (r_state == S_OP) begin
      r_result <= bus.as_result;
    end
  end

`ifdef ADDSUB_ARB_OVF_EN
  // Overflow flag registered alongside the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_OP) begin
      r_ovf <= ovf_calc(r_as_dataa, r_as_datab, bus.as_result, r_as_add_sub);
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.as_dataa   = r_as_dataa;
  assign bus.as_datab   = r_as_datab;
  assign bus.as_add_sub = r_as_add_sub;
  assign bus.grant      = r_grant;
  assign bus.done       = r_done;
  assign bus.result_out = r_result;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: reset, table-driven single
// operations, round-robin bursts, hand-written corner sequences and
// randomized bursts against a list-based round-robin reference model.
module tb_addsub_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  addsub_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  addsub_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // The shared combinational addsub unit.
  assign bus.as_result = bus.as_add_sub ? (bus.as_dataa + bus.as_datab)
                                        : (bus.as_dataa - bus.as_datab);

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;

  logic [WIDTH-1:0] opa [NREQ];
  logic [WIDTH-1:0] opb [NREQ];
  logic             opop[NREQ];

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic [WIDTH-1:0] res;
    logic             ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] ref_res(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic op);
    int full;
    full = op ? ($signed(a) + $signed(b)) : ($signed(a) - $signed(b));
    return WIDTH'(full);
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic op);
    int full;
    full = op ? ($signed(a) + $signed(b)) : ($signed(a) - $signed(b));
    return (full > 127) || (full < -128);
  endfunction

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic op);
    opa[i] = a; opb[i] = b; opop[i] = op;
    bus.dataa_in[i*WIDTH +: WIDTH] = a;
    bus.datab_in[i*WIDTH +: WIDTH] = b;
    bus.add_sub_in[i] = op;
  endtask

  // Post mask simultaneously from IDLE; expect service in circular order from
  // ptr_m, one grant/done pair every two cycles, then a return to IDLE.
  task automatic burst(input logic [NREQ-1:0] mask, input string tag, input bit scribble);
    int order[$];
    logic [WIDTH-1:0] exp_r[NREQ];
    logic             exp_o[NREQ];
    int j;
    for (int i = 0; i < NREQ; i++) begin
      exp_r[i] = ref_res(opa[i], opb[i], opop[i]);
      exp_o[i] = ref_ovf(opa[i], opb[i], opop[i]);
    end
    for (int k = 0; k < NREQ; k++) begin
      j = (ptr_m + k) % NREQ;
      if (mask[j]) order.push_back(j);
    end
    bus.req = mask;
    foreach (order[n]) begin
      j = order[n];
      step();
      check({tag, " grant"}, 32'(bus.grant), 32'(1 << j));
      check({tag, " done_low"}, 32'(bus.done), 32'h0);
      if (scribble) bus.dataa_in[j*WIDTH +: WIDTH] = WIDTH'($urandom);
      step();
      check({tag, " done"}, 32'(bus.done), 32'(1 << j));
      check({tag, " result"}, 32'(bus.result_out), 32'(exp_r[j]));
`ifdef ADDSUB_ARB_OVF_EN
      check({tag, " ovf"}, 32'(bus.ovf), 32'(exp_o[j]));
`endif
      bus.req[j] = 1'b0;
      ptr_m = (j + 1) % NREQ;
    end
    step();
    check({tag, " idle_grant"}, 32'(bus.grant), 32'h0);
    check({tag, " idle_done"}, 32'(bus.done), 32'h0);
  endtask

  // Structural invariants on every cycle while out of reset.
  always @(negedge clk) begin
    if (reset) begin
      check("grant_onehot", 32'($onehot0(bus.grant)), 32'h1);
      check("done_onehot", 32'($onehot0(bus.done)), 32'h1);
      check("grant_done_overlap", 32'(bus.grant & bus.done), 32'h0);
    end
  end

  initial begin
    vec_t tbl[7];
    logic [NREQ-1:0] m;

    tbl[0] = '{2, 8'h00, 8'hFF, 1'b1, 8'hFF, 1'b0};  //   0 + -1 = -1
    tbl[1] = '{0, 8'h06, 8'hFF, 1'b0, 8'h07, 1'b0};  //   6 - -1 = 7
    tbl[2] = '{0, 8'h09, 8'h02, 1'b0, 8'h07, 1'b0};  //   9 -  2 = 7
    tbl[3] = '{1, 8'd100, 8'd100, 1'b1, 8'hC8, 1'b1}; // 100+100 = -56
    tbl[4] = '{3, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1};  // -128 - 1 = 127
    tbl[5] = '{2, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0};  //   5 -  3 = 2
    tbl[6] = '{3, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b1};  // 127 +  1 = -128

    reset = 1'b0;
    bus.req = '0;
    bus.dataa_in = '0;
    bus.datab_in = '0;
    bus.add_sub_in = '0;
    for (int i = 0; i < NREQ; i++) set_ops(i, '0, '0, 1'b0);
    step();
    step();
    check("rst grant", 32'(bus.grant), 32'h0);
    check("rst done", 32'(bus.done), 32'h0);
    check("rst result", 32'(bus.result_out), 32'h0);
    check("rst as_dataa", 32'(bus.as_dataa), 32'h0);
    check("rst as_datab", 32'(bus.as_datab), 32'h0);
    check("rst as_add_sub", 32'(bus.as_add_sub), 32'h0);
`ifdef ADDSUB_ARB_OVF_EN
    check("rst ovf", 32'(bus.ovf), 32'h0);
`endif
    reset = 1'b1;
    ptr_m = 0;
    step();

    // Round robin from ptr 0, then wrap and serve requester 0 alone.
    for (int i = 0; i < NREQ; i++) set_ops(i, WIDTH'(10 * i + 3), WIDTH'(i), i[0]);
    burst(4'b1111, "rr", 1'b0);
    set_ops(0, 8'h11, 8'h22, 1'b1);
    burst(4'b0001, "rr_wrap", 1'b0);

    // Table of single operations with hand-computed results.
    for (int t = 0; t < 7; t++) begin
      set_ops(tbl[t].idx, tbl[t].a, tbl[t].b, tbl[t].op);
      bus.req[tbl[t].idx] = 1'b1;
      step();
      check("tbl grant", 32'(bus.grant), 32'(1 << tbl[t].idx));
      step();
      check("tbl done", 32'(bus.done), 32'(1 << tbl[t].idx));
      check("tbl result", 32'(bus.result_out), 32'(tbl[t].res));
`ifdef ADDSUB_ARB_OVF_EN
      check("tbl ovf", 32'(bus.ovf), 32'(tbl[t].ovf));
`endif
      bus.req[tbl[t].idx] = 1'b0;
      step();
      check("tbl done_low", 32'(bus.done), 32'h0);
      ptr_m = (tbl[t].idx + 1) % NREQ;
    end

    // Fairness: serve 1 so ptr is 2, then 0101 must go 2 then 0.
    set_ops(1, 8'h01, 8'h01, 1'b1);
    burst(4'b0010, "fair_pre", 1'b0);
    set_ops(0, 8'h40, 8'h01, 1'b0);
    set_ops(2, 8'h20, 8'h05, 1'b1);
    burst(4'b0101, "fair", 1'b0);

    // Winner drops req and changes operands during OP; done still pulses.
    set_ops(3, 8'h30, 8'h10, 1'b0);
    bus.req[3] = 1'b1;
    step();
    check("drop grant", 32'(bus.grant), 32'h8);
    bus.req[3] = 1'b0;
    bus.dataa_in[3*WIDTH +: WIDTH] = 8'hEE;
    bus.add_sub_in[3] = 1'b1;
    step();
    check("drop done", 32'(bus.done), 32'h8);
    check("drop result", 32'(bus.result_out), 32'h20);
    step();
    check("drop idle", 32'(bus.grant | bus.done), 32'h0);
    ptr_m = 0;

    // req held after done: DONE masks it, IDLE re-serves it.
    set_ops(1, 8'h05, 8'h05, 1'b1);
    bus.req[1] = 1'b1;
    step();
    check("hold grant1", 32'(bus.grant), 32'h2);
    step();
    check("hold done1", 32'(bus.done), 32'h2);
    step();
    check("hold masked", 32'(bus.grant), 32'h0);
    step();
    check("hold regrant", 32'(bus.grant), 32'h2);
    bus.req[1] = 1'b0;
    step();
    check("hold done2", 32'(bus.done), 32'h2);
    check("hold result2", 32'(bus.result_out), 32'h0A);
    step();
    ptr_m = 2;

    // Reset mid-OP: everything clears at once, the operation is lost.
    set_ops(1, 8'h33, 8'h11, 1'b1);
    bus.req[1] = 1'b1;
    step();
    check("mid grant", 32'(bus.grant), 32'h2);
    reset = 1'b0;
    #1;
    check("mid rst grant", 32'(bus.grant), 32'h0);
    check("mid rst done", 32'(bus.done), 32'h0);
    check("mid rst result", 32'(bus.result_out), 32'h0);
    check("mid rst as_dataa", 32'(bus.as_dataa), 32'h0);
    bus.req[1] = 1'b0;
    step();
    reset = 1'b1;
    ptr_m = 0;
    step();
    check("mid lost done a", 32'(bus.done), 32'h0);
    step();
    check("mid lost done b", 32'(bus.done), 32'h0);

    // Randomized bursts.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NREQ; i++)
        set_ops(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      burst(m, "rand", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares one combinational `addsub` unit among `NREQ` requesters. Each requester posts operands and an operation with a req/done handshake. The arbiter latches the winner's operands into registers that drive the `addsub` inputs, captures the `addsub` result one cycle later, and returns it with a one-cycle `done` pulse. It sits between client blocks (counters, control FSMs) and the single shared `addsub` datapath instance.

## Interface
- `WIDTH`, default 8: operand/result width, two's-complement signed.
- `NREQ`, default 4: number of requesters, 2..8.
- `IDXW`, default 2: index width, `$clog2(NREQ)`; derived, not overridden.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: request per requester; held high until that requester's `done`, then dropped on the next edge.
- `dataa_in`  in  NREQ*WIDTH: operand A for requester i at `[i*WIDTH +: WIDTH]`.
- `datab_in`  in  NREQ*WIDTH: operand B, same packing.
- `add_sub_in`  in  NREQ: 1 = add (A+B), 0 = subtract (A−B).
- `as_dataa`  out  WIDTH: registered operand A to `addsub.dataa`.
- `as_datab`  out  WIDTH: registered operand B to `addsub.datab`.
- `as_add_sub`  out  1: registered op to `addsub.add_sub`.
- `as_result`  in  WIDTH: combinational result from `addsub`.
- `grant`  out  NREQ: one-hot; owner of the shared unit, high in the OP state only.
- `done`  out  NREQ: one-hot, one-cycle pulse; `result_out` is valid in that cycle.
- `result_out`  out  WIDTH: captured result, held until the next capture.
- `ovf`  out  1: signed overflow of the last result; present only with `ADDSUB_ARB_OVF_EN`.

## Operation
- FSM states:
  - IDLE: nothing in flight.
  - OP: shared unit driven with the winner's operands.
  - DONE: result returned.
- Arbitration is round-robin. The search starts at `ptr` and proceeds `ptr`, `ptr+1`, … modulo NREQ. The first set bit of the eligible request vector wins.
- Eligible vector:
  - In IDLE: `req`.
  - In DONE: `req` with the current winner's bit masked.
- IDLE → OP when any eligible req is set. On that edge:
  - latch `idx`;
  - latch `as_dataa`/`as_datab`/`as_add_sub` from requester `idx`;
  - set `grant[idx]`.
- OP → DONE, unconditionally:
  - `result_out` ← `as_result`;
  - `done[idx]` ← 1;
  - `grant` ← 0.
- DONE:
  - `ptr` ← `idx+1` mod NREQ (wrap at NREQ−1 → 0).
  - If another eligible req is set, arbitrate from the new `ptr` and go directly to OP. Operands are latched and grant is set as from IDLE.
  - Otherwise go to IDLE.
- Arithmetic is `WIDTH`-bit two's complement with wrap-around; no saturation. For example, 127+1 = −128.
- Operands are sampled only at grant. Requester inputs may change freely afterwards.
- Boundary conditions:
  - **Winner drops `req` during OP:** the operation still completes and `done` still pulses.
  - **All NREQ requesting:** each is served exactly once per NREQ transactions, in index order from `ptr`.
  - **`req` still high in IDLE after its `done`:** treated as a new request. This is a client handshake violation, not detected by the arbiter.
  - **Reset asserted mid-operation:** immediate return to IDLE; the transaction is lost with no `done`.

## Timing
- Reset values:
  - state IDLE, `ptr` 0, `idx` 0;
  - `grant` 0, `done` 0, `result_out` 0;
  - `as_dataa` 0, `as_datab` 0, `as_add_sub` 0, `ovf` 0.
- Latency:
  - `req` sampled high at edge E0 (in IDLE) → `grant` high after E0.
  - `done` and `result_out` valid after E1.
  - `done` low after E2.
- Throughput: one operation per 2 cycles under back-to-back load (DONE → OP); 3 cycles from IDLE to return to IDLE.
- `as_result` must settle within one cycle, since `addsub` is combinational.
- `grant` and `done` are never high in the same cycle for the same index; at most one bit of each vector is set.

## Configuration
- `ADDSUB_ARB_OVF_EN` defined:
  - `ovf` port exists.
  - Registered on the OP → DONE edge alongside `result_out`.
  - Set when the signs of the effective operands are equal and the result sign differs. Effective operands are A and B for add, A and −B for subtract.
- Not defined:
  - `ovf` port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- **Reset:** assert `reset`=0 mid-OP with req[1] high → all outputs 0 immediately; after release, no `done` for the lost transaction.
- **Single add:** req[2], A=0, B=−1, `add_sub_in`=1 → `grant`=4'b0100 after E0; `done`=4'b0100, `result_out`=−1 after E1.
- **Single sub:** req[0], A=6, B=−1, op=0 → `result_out`=7; then A=9, B=2, op=0 → 7.
- **Round-robin:** req=4'b1111 held, each dropped after its done → done order 0, 1, 2, 3 at 2-cycle spacing; then ptr wraps and req[0] alone is served next.
- **Fairness after winner:** `ptr`=2, req=4'b0101 → index 2 served first, then 0.
- **Overflow** (`ADDSUB_ARB_OVF_EN`): 100+100 → `result_out`=−56, `ovf`=1; −128−1 → 127, `ovf`=1; 5−3 → 2, `ovf`=0.
